// File: rtl/u712_ram_arbiter_if.sv
// Chip RAM arbitration bus: requests and sequencer done in, grants and status out.
interface u712_ram_arbiter_if;
    logic       DMA_REQ;
    logic       CPU_REQ;
    logic       CYCLE_DONE;
    logic       DMA_GNT;
    logic       CPU_GNT;
    logic       REF_GNT;
    logic       BUSY;
    logic [2:0] REF_PEND;
    logic       REF_OVERRUN;
    logic       TIMEOUT_ERR;

    modport master (
        output DMA_REQ, CPU_REQ, CYCLE_DONE,
        input  DMA_GNT, CPU_GNT, REF_GNT, BUSY, REF_PEND, REF_OVERRUN, TIMEOUT_ERR
    );

    modport slave (
        input  DMA_REQ, CPU_REQ, CYCLE_DONE,
        output DMA_GNT, CPU_GNT, REF_GNT, BUSY, REF_PEND, REF_OVERRUN, TIMEOUT_ERR
    );
endinterface

// File: rtl/u712_ram_arbiter.sv
// Chip RAM arbiter for Agnus DMA, the 68040 and DRAM refresh, with precharge
// recovery, refresh backlog tracking and a grant watchdog.
module u712_ram_arbiter #(
    parameter int REF_INTERVAL   = 312,
    parameter int REF_URGENT     = 4,
    parameter int RECOVER_CYCLES = 2,
    parameter int TIMEOUT        = 64
) (
    input logic               CLK40,
    input logic               RESET,
    u712_ram_arbiter_if.slave bus
);
    localparam int RC_W  = $clog2(REF_INTERVAL);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int REC_W = $clog2(RECOVER_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DMA,
        ST_CPU,
        ST_REF,
        ST_RECOVER
    } state_t;

    state_t             state_q, state_d;
    logic [REC_W-1:0]   rec_cnt_q, rec_cnt_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic [RC_W-1:0]    ref_cnt_q, ref_cnt_d;
    logic [2:0]         ref_pend_q, ref_pend_d;
    logic               ref_overrun_q, ref_overrun_d;
    logic               timeout_err_q, timeout_err_d;
    logic               dma_gnt_q, dma_gnt_d;
    logic               cpu_gnt_q, cpu_gnt_d;
    logic               ref_gnt_q, ref_gnt_d;
    logic               busy_q, busy_d;
    logic               ref_take;
    logic               tick;

    always_comb begin
        state_d       = state_q;
        rec_cnt_d     = rec_cnt_q;
        wdog_d        = wdog_q;
        timeout_err_d = timeout_err_q;
        ref_take      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (int'(ref_pend_q) >= REF_URGENT)
                    state_d = ST_REF;
                else if (bus.DMA_REQ)
                    state_d = ST_DMA;
                else if (ref_pend_q != 3'd0)
                    state_d = ST_REF;
                else if (bus.CPU_REQ)
                    state_d = ST_CPU;
                wdog_d   = '0;
                ref_take = (state_d == ST_REF);
            end
            ST_DMA, ST_CPU, ST_REF: begin
                wdog_d = wdog_q + WD_W'(1);
                // A watchdog abort of a refresh still counts: the backlog was already taken on entry.
                if (bus.CYCLE_DONE) begin
                    state_d   = ST_RECOVER;
                    rec_cnt_d = '0;
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    state_d       = ST_RECOVER;
                    rec_cnt_d     = '0;
                    timeout_err_d = 1'b1;
                end
            end
            ST_RECOVER: begin
                if (rec_cnt_q == REC_W'(RECOVER_CYCLES - 1))
                    state_d = ST_IDLE;
                else
                    rec_cnt_d = rec_cnt_q + REC_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tick          = (ref_cnt_q == RC_W'(REF_INTERVAL - 1));
        ref_cnt_d     = tick ? '0 : ref_cnt_q + RC_W'(1);
        ref_pend_d    = ref_pend_q;
        ref_overrun_d = ref_overrun_q;
        // A tick and a refresh start in the same cycle cancel out.
        if (tick && !ref_take) begin
            if (ref_pend_q == 3'd7)
                ref_overrun_d = 1'b1;
            else
                ref_pend_d = ref_pend_q + 3'd1;
        end else if (!tick && ref_take) begin
            ref_pend_d = ref_pend_q - 3'd1;
        end
        dma_gnt_d = (state_d == ST_DMA);
        cpu_gnt_d = (state_d == ST_CPU);
        ref_gnt_d = (state_d == ST_REF);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK40) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            rec_cnt_q     <= '0;
            wdog_q        <= '0;
            ref_cnt_q     <= '0;
            ref_pend_q    <= 3'd0;
            ref_overrun_q <= 1'b0;
            timeout_err_q <= 1'b0;
            dma_gnt_q     <= 1'b0;
            cpu_gnt_q     <= 1'b0;
            ref_gnt_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rec_cnt_q     <= rec_cnt_d;
            wdog_q        <= wdog_d;
            ref_cnt_q     <= ref_cnt_d;
            ref_pend_q    <= ref_pend_d;
            ref_overrun_q <= ref_overrun_d;
            timeout_err_q <= timeout_err_d;
            dma_gnt_q     <= dma_gnt_d;
            cpu_gnt_q     <= cpu_gnt_d;
            ref_gnt_q     <= ref_gnt_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.DMA_GNT     = dma_gnt_q;
    assign bus.CPU_GNT     = cpu_gnt_q;
    assign bus.REF_GNT     = ref_gnt_q;
    assign bus.BUSY        = busy_q;
    assign bus.REF_PEND    = ref_pend_q;
    assign bus.REF_OVERRUN = ref_overrun_q;
    assign bus.TIMEOUT_ERR = timeout_err_q;
endmodule

// File: tb/tb_u712_ram_arbiter.sv
// Bench for u712_ram_arbiter: directed timing cases plus random traffic checked
// every cycle against an owner/backlog model of the arbitration rules.
module tb_u712_ram_arbiter;
    localparam int P_INT = 20;
    localparam int P_URG = 4;
    localparam int P_REC = 2;
    localparam int P_TO  = 64;

    logic CLK40 = 1'b0;
    logic RESET;

    u712_ram_arbiter_if bus();

    u712_ram_arbiter #(
        .REF_INTERVAL  (P_INT),
        .REF_URGENT    (P_URG),
        .RECOVER_CYCLES(P_REC),
        .TIMEOUT       (P_TO)
    ) dut (
        .CLK40(CLK40),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLK40 = ~CLK40;

    int total = 0;
    int bad   = 0;

    // Model: owner 0=none 1=DMA 2=CPU 3=refresh; left = recovery cycles remaining.
    int m_owner, m_left, m_age, m_pend, m_phase;
    bit m_overrun, m_terr;
    bit m_valid = 1'b0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit dma, input bit cpu, input bit done);
        RESET          = rst;
        bus.DMA_REQ    = dma;
        bus.CPU_REQ    = cpu;
        bus.CYCLE_DONE = done;
    endtask

    task automatic modelStep();
        int tick;
        int took;
        int nxt;
        if (RESET) begin
            m_owner = 0; m_left = 0; m_age = 0; m_pend = 0; m_phase = 0;
            m_overrun = 1'b0; m_terr = 1'b0; m_valid = 1'b1;
            return;
        end
        tick    = (m_phase == P_INT - 1) ? 1 : 0;
        m_phase = (m_phase + 1) % P_INT;
        took    = 0;
        if (m_owner != 0) begin
            m_age++;
            if (bus.CYCLE_DONE || m_age == P_TO) begin
                if (!bus.CYCLE_DONE) m_terr = 1'b1;
                m_owner = 0;
                m_left  = P_REC;
            end
        end else if (m_left > 0) begin
            m_left--;
        end else begin
            if (m_pend >= P_URG)   m_owner = 3;
            else if (bus.DMA_REQ)  m_owner = 1;
            else if (m_pend > 0)   m_owner = 3;
            else if (bus.CPU_REQ)  m_owner = 2;
            m_age = 0;
            if (m_owner == 3) took = 1;
        end
        nxt = m_pend + tick - took;
        if (nxt > 7) begin
            nxt       = 7;
            m_overrun = 1'b1;
        end
        m_pend = nxt;
    endtask

    task automatic compareModel();
        if (!m_valid) return;
        checkOutput("dma_gnt",     int'(bus.DMA_GNT),     int'(m_owner == 1));
        checkOutput("cpu_gnt",     int'(bus.CPU_GNT),     int'(m_owner == 2));
        checkOutput("ref_gnt",     int'(bus.REF_GNT),     int'(m_owner == 3));
        checkOutput("busy",        int'(bus.BUSY),        int'(m_owner != 0 || m_left > 0));
        checkOutput("ref_pend",    int'(bus.REF_PEND),    m_pend);
        checkOutput("ref_overrun", int'(bus.REF_OVERRUN), int'(m_overrun));
        checkOutput("timeout_err", int'(bus.TIMEOUT_ERR), int'(m_terr));
    endtask

    task automatic stepCycle();
        @(posedge CLK40);
        modelStep();
        @(negedge CLK40);
        compareModel();
    endtask

    // Leaves RESET high; the caller's next applyStimulus is driven in cycle 0.
    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        stepCycle();
        stepCycle();
    endtask

    initial begin
        int peak;
        int seen;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

        doReset();
        checkOutput("rst_dma_gnt", int'(bus.DMA_GNT), 0);
        checkOutput("rst_cpu_gnt", int'(bus.CPU_GNT), 0);
        checkOutput("rst_ref_gnt", int'(bus.REF_GNT), 0);
        checkOutput("rst_busy",    int'(bus.BUSY), 0);
        checkOutput("rst_pend",    int'(bus.REF_PEND), 0);
        checkOutput("rst_overrun", int'(bus.REF_OVERRUN), 0);
        checkOutput("rst_terr",    int'(bus.TIMEOUT_ERR), 0);

        // Single DMA access with done at cycle 5
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        stepCycle();
        checkOutput("dma_gnt_c1", int'(bus.DMA_GNT), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) stepCycle();
        checkOutput("dma_gnt_c5", int'(bus.DMA_GNT), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        stepCycle();
        checkOutput("dma_gnt_c6", int'(bus.DMA_GNT), 0);
        checkOutput("busy_c6", int'(bus.BUSY), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("busy_c7", int'(bus.BUSY), 1);
        stepCycle();
        checkOutput("busy_c8", int'(bus.BUSY), 0);

        // DMA beats CPU; CPU follows three cycles after DMA falls
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        stepCycle();
        checkOutput("prio_dma_first", int'(bus.DMA_GNT), 1);
        checkOutput("prio_cpu_wait",  int'(bus.CPU_GNT), 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        stepCycle();
        checkOutput("prio_dma_fall", int'(bus.DMA_GNT), 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        stepCycle();
        stepCycle();
        checkOutput("prio_cpu_gap", int'(bus.CPU_GNT), 0);
        stepCycle();
        checkOutput("prio_cpu_rise", int'(bus.CPU_GNT), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) stepCycle();

        // Continuous DMA: backlog climbs to 4, then refresh preempts
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        peak = 0;
        seen = 0;
        for (int i = 0; i < 6 * P_INT; i++) begin
            stepCycle();
            if (bus.REF_GNT) begin
                seen = 1;
                break;
            end
            if (int'(bus.REF_PEND) > peak) peak = int'(bus.REF_PEND);
        end
        checkOutput("urgent_ref_seen", seen, 1);
        checkOutput("urgent_peak",     peak, 4);
        checkOutput("urgent_pend_after", int'(bus.REF_PEND), 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (20) stepCycle();

        // Watchdog: CPU grant with no done lasts exactly 64 cycles
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (P_TO - 1) stepCycle();
        checkOutput("wd_cpu_c64",  int'(bus.CPU_GNT), 1);
        checkOutput("wd_terr_c64", int'(bus.TIMEOUT_ERR), 0);
        stepCycle();
        checkOutput("wd_cpu_c65",  int'(bus.CPU_GNT), 0);
        checkOutput("wd_terr_c65", int'(bus.TIMEOUT_ERR), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (100) stepCycle();
        checkOutput("wd_terr_sticky", int'(bus.TIMEOUT_ERR), 1);
        doReset();
        checkOutput("wd_terr_cleared", int'(bus.TIMEOUT_ERR), 0);

        // Tick lands on the IDLE->REF transition at the end of cycle 39
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (35) stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        stepCycle();
        checkOutput("coin_idle_c39", int'(bus.BUSY), 0);
        checkOutput("coin_pend_c39", int'(bus.REF_PEND), 1);
        stepCycle();
        checkOutput("coin_ref_c40",  int'(bus.REF_GNT), 1);
        checkOutput("coin_pend_c40", int'(bus.REF_PEND), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (5) stepCycle();

        // Reset in the middle of a CPU grant
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        stepCycle();
        checkOutput("midrst_cpu_on", int'(bus.CPU_GNT), 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("midrst_cpu",  int'(bus.CPU_GNT), 0);
        checkOutput("midrst_busy", int'(bus.BUSY), 0);
        checkOutput("midrst_pend", int'(bus.REF_PEND), 0);

        // Hung refresh grants let the backlog saturate and overrun
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        seen = 0;
        for (int i = 0; i < 3000; i++) begin
            stepCycle();
            if (bus.REF_OVERRUN) begin
                seen = 1;
                break;
            end
        end
        checkOutput("ovr_seen", seen, 1);
        checkOutput("ovr_pend", int'(bus.REF_PEND), 7);
        repeat (50) stepCycle();

        // Random traffic with occasional stalls and resets
        doReset();
        for (int i = 0; i < 8000; i++) begin
            bit done;
            if ((i / 400) % 4 == 3)
                done = 1'b0;
            else
                done = ($urandom_range(0, 3) == 0);
            applyStimulus($urandom_range(0, 999) == 0,
                          $urandom_range(0, 2) == 0,
                          $urandom_range(0, 1) == 0,
                          done);
            stepCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
